// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } serial_sub_state_t;

    localparam int SERIAL_SUB_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first, one full_subtractor cell.
// Optional signed-overflow output built when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SERIAL_SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    serial_sub_state_t state, nstate;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             fs_d;
    logic             fs_bout;
    logic             last;

    full_subtractor u_fs (
        .a    (sa[0]),
        .b    (sb[0]),
        .bin  (br),
        .d    (fs_d),
        .bout (fs_bout)
    );

    assign last = (cnt == CW'(WIDTH - 1));

    // New difference bit enters at the MSB; the result that lands in diff is this next value.
    assign res_next = (res >> 1) | {fs_d, {(WIDTH-1){1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        ready  = 1'b0;
        done   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) nstate = RUN;
            end
            RUN: begin
                if (last) nstate = DONE;
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            res        <= '0;
            cnt        <= '0;
            br         <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= res_next;
                    br  <= fs_bout;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        diff       <= res_next;
                        borrow_out <= fs_bout;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
            end
            if (state == RUN && last) begin
                ovf <= (a_msb != b_msb) && (fs_d != a_msb);
            end
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         ready;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         ovf;

    int nchecks = 0;
    int nerrs   = 0;
    logic [W-1:0] exp_last_diff = '0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a_i),
        .b          (b_i),
        .ready      (ready),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W-1:0] m_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        int r;
        r = int'(x) - int'(y);
        return W'(r);
    endfunction

    function automatic logic m_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return (int'(x) < int'(y));
    endfunction

    function automatic logic m_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_SUB_OVF_EN
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = sx - sy;
        return (r > 127) || (r < -128);
`else
        return 1'b0 & x[0] & y[0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the DUT in IDLE.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit disturb);
        int  n;
        bit  got;
        int  extra;
        a_i = x; b_i = y; start = 1'b1;
        tick();
        start = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom);
        chk("run_not_ready", ready, 0);
        n = 1; got = 0;
        while (n <= 3 * W && !got) begin
            if (disturb && n == 3) begin
                start = 1'b1; a_i = 8'h33; b_i = 8'h11;
            end else begin
                start = 1'b0;
            end
            if (!got && n < W + 1) chk("diff_hold_run", diff, exp_last_diff);
            tick();
            n++;
            if (done) got = 1;
            else if (disturb) chk("ready_low_busy", ready, 0);
        end
        chk("done_seen", got, 1);
        chk("latency", n, W + 1);
        chk("diff", diff, m_diff(x, y));
        chk("borrow", borrow_out, m_borrow(x, y));
        chk("ovf", ovf, m_ovf(x, y));
        exp_last_diff = m_diff(x, y);
        if (disturb) begin
            start = 1'b1; a_i = 8'h33; b_i = 8'h11;
        end
        tick();
        chk("done_one_cycle", done, 0);
        chk("ready_after", ready, 1);
        start = 1'b0;
        if (disturb) begin
            extra = 0;
            for (int i = 0; i < W + 3; i++) begin
                tick();
                if (done) extra++;
            end
            chk("no_second_done", extra, 0);
            chk("diff_kept", diff, exp_last_diff);
        end
    endtask

    initial begin
        int accepts[$];
        logic [W-1:0] qd[$];
        logic         qb[$];
        logic         prev_ready;
        logic         prev_done;
        logic [W-1:0] cur_a, cur_b;
        int           cnt_done;

        rst_n = 1'b0; start = 1'b0; a_i = '0; b_i = '0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        do_op(8'h5A, 8'h23, 0);
        do_op(8'h10, 8'h20, 0);
        do_op(8'h80, 8'h01, 0);
        do_op(8'h00, 8'hFF, 1);

        // Reset during the 4th RUN cycle discards the operation.
        a_i = 8'hFF; b_i = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_diff", diff, 0);
        chk("mid_rst_borrow", borrow_out, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_last_diff = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cnt_done = 0;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            if (done) cnt_done++;
        end
        chk("mid_rst_no_done", cnt_done, 0);
        chk("mid_rst_diff_hold", diff, 0);
        do_op(8'h05, 8'h03, 0);

        for (int i = 0; i < 25; i++) begin
            do_op(W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Back-to-back with start held high.
        prev_done = 1'b0;
        cur_a = W'($urandom); cur_b = W'($urandom);
        a_i = cur_a; b_i = cur_b; start = 1'b1;
        for (int cyc = 0; cyc < 45; cyc++) begin
            prev_ready = ready;
            tick();
            if (prev_ready) begin
                accepts.push_back(cyc);
                qd.push_back(m_diff(cur_a, cur_b));
                qb.push_back(m_borrow(cur_a, cur_b));
            end
            if (done) begin
                chk("b2b_done_width", prev_done, 0);
                chk("b2b_have_expect", qd.size() > 0, 1);
                if (qd.size() > 0) begin
                    exp_last_diff = qd.pop_front();
                    chk("b2b_diff", diff, exp_last_diff);
                    chk("b2b_borrow", borrow_out, qb.pop_front());
                end
            end else begin
                chk("b2b_diff_stable", diff, exp_last_diff);
            end
            prev_done = done;
            cur_a = W'($urandom); cur_b = W'($urandom);
            a_i = cur_a; b_i = cur_b;
        end
        start = 1'b0;
        chk("b2b_accept_count", accepts.size(), 5);
        for (int i = 1; i < accepts.size(); i++) begin
            chk("b2b_interval", accepts[i] - accepts[i-1], W + 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
